vram_wr_sched: RTL
==================

# vram_wr_sched

Write-port scheduler for the 16-bit-wide video dual-port RAM (8-bit bitmap plus 8-bit colour per byte cell). It sits between the CPU bus and the RAM write port, in the `clk_ram` domain. It decodes CPU writes to the video window 0x9000–0xBFFF, buffers them in a small FIFO, and interleaves them with a hardware screen-fill engine that clears or fills the whole 12 KB bitmap. The read port is untouched; the pixel fetch keeps full ownership of it.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — CPU write FIFO entries; power of two, 2..16.
- `FILL_SHARE`, 4 — while fill and CPU traffic compete, fill receives 1 of every `FILL_SHARE` write slots; range 2..15.

Ports:
- `clk_ram` in 1 — video RAM clock (>50 MHz); the only clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `cpu_we` in 1 — single-cycle CPU write strobe.
- `cpu_addr` in 16 — CPU address.
- `cpu_data` in 8 — bitmap byte.
- `cpu_color` in 8 — colour attribute latched with the write.
- `fill_start` in 1 — single-cycle pulse; start or restart the fill.
- `fill_data` in 8 — bitmap byte for the fill.
- `fill_color` in 8 — colour byte for the fill.
- `ovf_clr` in 1 — clears `overflow`.
- `wr_en` out 1 — RAM write enable.
- `wr_addr` out 14 — RAM word address, 0x0000–0x2FFF.
- `wr_data` out 16 — {colour, bitmap}.
- `fill_busy` out 1 — fill engine running.
- `fifo_full` out 1 — FIFO holds `FIFO_DEPTH` entries.
- `overflow` out 1 — sticky flag: a CPU write was dropped.

## Operation
- Decode: a write hits when `cpu_we` & `cpu_addr[15]` & ~`cpu_addr[14]` & (`cpu_addr[13]` | `cpu_addr[12]`).
  - Offset = `cpu_addr[13:0]` − 14'h1000, computed modulo 2^14, so the result is 0x0000–0x2FFF.
  - A hit pushes {offset, `cpu_color`, `cpu_data`} into the FIFO. A non-hit is ignored.
- FIFO push when full: the write is dropped and `overflow` is set. A push and a pop in the same cycle while full is accepted.
- Fill engine FSM:
  - IDLE: on `fill_start`, capture `fill_data` and `fill_color`, set fill address to 0, go to RUN.
  - RUN: each fill grant writes the current address and increments it. After the grant at 0x2FFF, return to IDLE.
  - `fill_start` during RUN restarts from address 0 with newly captured data.
- Arbitration, once per cycle, in this priority order:
  - (a) FIFO empty and RUN → fill.
  - (b) FIFO non-empty and not RUN → CPU.
  - (c) Both pending → CPU, unless `share_cnt` = `FILL_SHARE`−1, in which case fill.
  - (d) Neither pending → no write.
- `share_cnt` increments on each CPU grant made under (c), resets to 0 on every fill grant, and resets to 0 when not in RUN.
- Coherence: writes reach RAM in grant order. A CPU write to a cell the fill has not yet reached is overwritten by the fill. Software waits for `fill_busy` low before drawing.
- `ovf_clr` takes effect in the same cycle as a new overflow event; the set wins.

## Timing
- All outputs are registered. Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `fill_busy`=0, `fifo_full`=0, `overflow`=0. Reset empties the FIFO, puts the FSM in IDLE and clears `share_cnt`.
- CPU latency: a hit at edge N with an empty FIFO and no fill competing gives `wr_en`=1 with that data after edge N+1.
- Fill latency: `fill_start` at edge N sets `fill_busy`=1 after edge N+1. The first fill write (address 0) is presented after edge N+2.
- Uncontended fill: 12288 consecutive `wr_en` cycles. `fill_busy` drops in the cycle after the address-0x2FFF write is presented.
- Sustained CPU throughput: one write per cycle, except one slot in every `FILL_SHARE` while RUN.
- `reset_n` asserted mid-fill or mid-FIFO: all state is discarded immediately. No partial write is presented after reset asserts.

## Configuration
- `VRAM_SCHED_FILL_EN` defined: fill engine, `share_cnt` and arbitration rules (a)–(c) are compiled in.
- Not defined: no fill logic.
  - `fill_start`, `fill_data` and `fill_color` are ignored.
  - `fill_busy` is constant 0.
  - Every write slot goes to the FIFO, so a CPU write appears one cycle after its strobe.

## Test plan
- Reset then single write to 0x9000 (data 0xA5, colour 0x70) → next cycle `wr_en`=1, `wr_addr`=0x0000, `wr_data`=0x70A5. Write to 0xC000 → no `wr_en`.
- Write to 0xBFFF → `wr_addr`=0x2FFF. Write to 0x8FFF → ignored.
- `fill_start` (data 0x00, colour 0x0F) with no CPU traffic → 12288 writes, addresses 0..0x2FFF consecutive, each 0x0F00. `fill_busy` falls after the last write.
- Fill running with CPU strobes every cycle, `FILL_SHARE`=4 → grant pattern CPU,CPU,CPU,fill repeating. `fifo_full` rises and `overflow` sets. `ovf_clr` clears it.
- `fill_start` again at fill address 0x1234 → next fill write is at 0x0000 with the new data.
- `reset_n` low for one cycle during a fill with 3 FIFO entries → all outputs 0. Nothing is written after release until new stimulus arrives.

Source files
------------

// File: rtl/vram_wr_sched.sv
// vram_wr_sched: CPU write FIFO and screen-fill engine sharing the video RAM write port.
// Define VRAM_SCHED_FILL_EN to build the fill engine; without it every write slot serves the FIFO.
module vram_wr_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FILL_SHARE = 4
) (
    input  logic        clk_ram,
    input  logic        reset_n,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic [7:0]  cpu_color,
    input  logic        fill_start,
    input  logic [7:0]  fill_data,
    input  logic [7:0]  fill_color,
    input  logic        ovf_clr,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        fill_busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [13:0]   WIN_BASE = 14'h1000;

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  color;
        logic [7:0]  data;
    } wr_ent_t;

    wr_ent_t        fifo_mem [FIFO_DEPTH];
    wr_ent_t        head;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [13:0]    cpu_off;
    logic           hit;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           drop;
    logic           grant_cpu;

    assign hit        = cpu_we & cpu_addr[15] & ~cpu_addr[14] & (cpu_addr[13] | cpu_addr[12]);
    assign cpu_off    = cpu_addr[13:0] - WIN_BASE;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign pop        = grant_cpu;
    // A full FIFO still accepts a write when the head leaves in the same slot.
    assign push       = hit & ((count != DEPTH_C) | pop);
    assign drop       = hit & ~push;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: cpu_off, color: cpu_color, data: cpu_data};
        end
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            fifo_full <= (count_nxt == DEPTH_C);
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef VRAM_SCHED_FILL_EN
    typedef enum logic {F_IDLE, F_RUN} fill_state_t;

    localparam logic [3:0]  SHARE_LAST = 4'(FILL_SHARE - 1);
    localparam logic [13:0] FILL_LAST  = 14'h2FFF;

    fill_state_t state;
    fill_state_t state_nxt;
    logic [13:0] fill_addr;
    logic [13:0] fill_addr_nxt;
    logic [7:0]  fill_d_q;
    logic [7:0]  fill_c_q;
    logic [3:0]  share_cnt;
    logic [3:0]  share_nxt;
    logic        fill_busy_q;
    logic        fill_pend;
    logic        grant_fill;

    // fill_busy trails the FSM by one cycle; fill only competes once it is visible.
    assign fill_pend = (state == F_RUN) & fill_busy_q;
    assign fill_busy = fill_busy_q;

    always_comb begin
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        if (fill_pend && fifo_empty) begin
            grant_fill = 1'b1;
        end else if (!fill_pend && !fifo_empty) begin
            grant_cpu = 1'b1;
        end else if (fill_pend && !fifo_empty) begin
            if (share_cnt == SHARE_LAST) grant_fill = 1'b1;
            else                         grant_cpu  = 1'b1;
        end
    end

    always_comb begin
        share_nxt = share_cnt;
        if (!fill_pend || grant_fill) share_nxt = '0;
        else if (grant_cpu)           share_nxt = share_cnt + 4'd1;
    end

    always_comb begin
        state_nxt     = state;
        fill_addr_nxt = fill_addr;
        case (state)
            F_IDLE: begin
                if (fill_start) begin
                    state_nxt     = F_RUN;
                    fill_addr_nxt = '0;
                end
            end
            F_RUN: begin
                if (fill_start) begin
                    fill_addr_nxt = '0;
                end else if (grant_fill) begin
                    if (fill_addr == FILL_LAST) begin
                        state_nxt     = F_IDLE;
                        fill_addr_nxt = '0;
                    end else begin
                        fill_addr_nxt = fill_addr + 14'd1;
                    end
                end
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state       <= F_IDLE;
            fill_addr   <= '0;
            fill_d_q    <= '0;
            fill_c_q    <= '0;
            share_cnt   <= '0;
            fill_busy_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill_addr   <= fill_addr_nxt;
            share_cnt   <= share_nxt;
            fill_busy_q <= (state == F_RUN);
            if (fill_start) begin
                fill_d_q <= fill_data;
                fill_c_q <= fill_color;
            end
        end
    end
`else
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_data, fill_color};
    assign grant_cpu   = ~fifo_empty;
    assign fill_busy   = 1'b0;
`endif

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
`ifdef VRAM_SCHED_FILL_EN
            wr_en <= grant_cpu | grant_fill;
`else
            wr_en <= grant_cpu;
`endif
            if (grant_cpu) begin
                wr_addr <= head.addr;
                wr_data <= {head.color, head.data};
            end
`ifdef VRAM_SCHED_FILL_EN
            else if (grant_fill) begin
                wr_addr <= fill_addr;
                wr_data <= {fill_c_q, fill_d_q};
            end
`endif
        end
    end

endmodule
